// File: rtl/wf_playback_ctrl.sv
// Waveform playback sequencer: reads len samples from the DPBRAM at a fixed sample
// period, repeats for cycle_num passes (0 = forever), and strobes each sample out.
module wf_playback_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int DIV_WIDTH  = 32,
  parameter int CYC_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wf_mode_start,
  input  logic                  i_wf_write_en,
  input  logic [ADDR_WIDTH:0]   i_wf_len,
  input  logic [DIV_WIDTH-1:0]  i_wf_step_div,
  input  logic [CYC_WIDTH-1:0]  i_wf_cycle_num,
  output logic                  o_bram_rd_en,
  output logic [ADDR_WIDTH-1:0] o_bram_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_bram_rd_data,
  output logic [DATA_WIDTH-1:0] o_wf_data,
  output logic                  o_wf_data_valid,
  output logic [31:0]           o_wf_read_cnt,
  output logic                  o_wf_busy,
  output logic                  o_wf_done,
  output logic                  o_wf_err
);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_WAIT, S_RUN, S_DONE} state_t;

  localparam logic [ADDR_WIDTH:0] LEN_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                r_state, w_next;
  logic                  r_start_d;
  logic [ADDR_WIDTH:0]   r_len;
  logic [DIV_WIDTH-1:0]  r_div, r_div_cnt;
  logic [CYC_WIDTH-1:0]  r_cyc_num, r_cyc_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_prefetch, r_data;
  logic                  r_rd_pend, r_valid, r_err;
  logic [31:0]           r_read_cnt;

  logic                  w_start_pulse, w_bad_params, w_accept, w_reject;
  logic                  w_active, w_abort, w_tick, w_last_addr, w_finish;
  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic [CYC_WIDTH-1:0]  w_cyc_next;
  logic                  w_rd_en;

  assign w_start_pulse = i_wf_mode_start & ~r_start_d;
  assign w_bad_params  = (i_wf_len == '0) || (i_wf_len > LEN_MAX) ||
                         (i_wf_step_div < DIV_WIDTH'(2)) || i_wf_write_en;
  assign w_accept      = (r_state == S_IDLE) & w_start_pulse & ~w_bad_params;
  assign w_reject      = (r_state == S_IDLE) & w_start_pulse &  w_bad_params;
  assign w_active      = (r_state == S_PREP) | (r_state == S_WAIT) | (r_state == S_RUN);
  // Abort takes priority over a tick landing in the same clock.
  assign w_abort       = w_active & (~i_wf_mode_start | i_wf_write_en);
  assign w_tick        = (r_state == S_RUN) & (r_div_cnt == '0) & ~w_abort;
  assign w_last_addr   = ({1'b0, r_addr} == (r_len - (ADDR_WIDTH+1)'(1)));
  assign w_next_addr   = w_last_addr ? '0 : r_addr + ADDR_WIDTH'(1);
  assign w_cyc_next    = w_last_addr ? r_cyc_cnt + CYC_WIDTH'(1) : r_cyc_cnt;
  assign w_finish      = w_tick & w_last_addr & (r_cyc_num != '0) & (w_cyc_next == r_cyc_num);
  assign w_rd_en       = (r_state == S_PREP) | (w_tick & ~w_finish);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_PREP;
      S_PREP: w_next = S_WAIT;
      S_WAIT: w_next = S_RUN;
      S_RUN:  if (w_finish) w_next = S_DONE;
      S_DONE: if (!i_wf_mode_start) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
  end

  // r_start_d resets high so a start level held through reset is not taken as an edge.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= S_IDLE;
      r_start_d  <= 1'b1;
      r_len      <= '0;
      r_div      <= '0;
      r_cyc_num  <= '0;
      r_addr     <= '0;
      r_div_cnt  <= '0;
      r_cyc_cnt  <= '0;
      r_prefetch <= '0;
      r_rd_pend  <= 1'b0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_read_cnt <= '0;
    end else begin
      r_state   <= w_next;
      r_start_d <= i_wf_mode_start;
      r_err     <= w_reject | (w_abort & i_wf_write_en);
      r_valid   <= w_tick;
      r_rd_pend <= w_rd_en;
      if (r_rd_pend) r_prefetch <= i_bram_rd_data;
      if (r_state == S_RUN)
        r_div_cnt <= (r_div_cnt == r_div - DIV_WIDTH'(1)) ? '0 : r_div_cnt + DIV_WIDTH'(1);
      if (w_tick) begin
        r_data    <= r_prefetch;
        r_addr    <= w_next_addr;
        r_cyc_cnt <= w_cyc_next;
        if (r_read_cnt != '1) r_read_cnt <= r_read_cnt + 32'd1;
      end
      if (w_accept) begin
        r_len      <= i_wf_len;
        r_div      <= i_wf_step_div;
        r_cyc_num  <= i_wf_cycle_num;
        r_addr     <= '0;
        r_div_cnt  <= '0;
        r_cyc_cnt  <= '0;
        r_read_cnt <= '0;
      end
    end
  end

  assign o_bram_rd_en    = w_rd_en;
  assign o_bram_rd_addr  = w_tick ? w_next_addr : '0;
  assign o_wf_data       = r_data;
  assign o_wf_data_valid = r_valid;
  assign o_wf_read_cnt   = r_read_cnt;
  assign o_wf_busy       = w_active;
  assign o_wf_done       = (r_state == S_DONE);
  assign o_wf_err        = r_err;

endmodule

// File: tb/tb_wf_playback_ctrl.sv
// Bench for wf_playback_ctrl: random RAM contents and run parameters, with expected
// strobe times/data/counts derived from the playback rules by plain arithmetic.
module tb_wf_playback_ctrl;
  localparam int AW = 10;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, wr_en = 1'b0;
  logic [AW:0]   len = '0;
  logic [31:0]   div = '0;
  logic [15:0]   cnum = '0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic [DW-1:0] wf_data;
  logic          wf_valid, busy, done, err;
  logic [31:0]   rcnt;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  int unsigned   cycnt = 0;
  int            n_cmp = 0, n_bad = 0, err_cnt = 0;
  int            st_t[$];
  logic [DW-1:0] st_d[$];
  logic [31:0]   st_c[$];
  int            rd_a[$];

  wf_playback_ctrl dut (
    .i_clk(clk), .i_rst(rst_n), .i_wf_mode_start(start), .i_wf_write_en(wr_en),
    .i_wf_len(len), .i_wf_step_div(div), .i_wf_cycle_num(cnum),
    .o_bram_rd_en(rd_en), .o_bram_rd_addr(rd_addr), .i_bram_rd_data(rd_data),
    .o_wf_data(wf_data), .o_wf_data_valid(wf_valid), .o_wf_read_cnt(rcnt),
    .o_wf_busy(busy), .o_wf_done(done), .o_wf_err(err));

  always #5 clk = ~clk;
  always @(posedge clk) cycnt <= cycnt + 1;
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  always @(negedge clk) begin
    if (wf_valid) begin st_t.push_back(int'(cycnt)); st_d.push_back(wf_data); st_c.push_back(rcnt); end
    if (rd_en) rd_a.push_back(int'(rd_addr));
    if (err) err_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic clear_mon();
    st_t.delete(); st_d.delete(); st_c.delete(); rd_a.delete();
  endtask

  // Finite run: strobe k lands 4 clocks after the start edge plus k sample periods.
  task automatic run_finite(input int l, input int d, input int c);
    int c0, n, e0;
    clear_mon();
    len = (AW+1)'(l); div = d; cnum = 16'(c);
    step();
    start = 1'b1; c0 = int'(cycnt); e0 = err_cnt;
    step();
    chk("cnt_clear", rcnt, 0);
    chk("busy_prep", busy, 1);
    n = l * c;
    for (int i = 0; i < n * d + 20 && !done; i++) step();
    repeat (d + 2) step();
    chk("n_strobes", st_d.size(), n);
    for (int k = 0; k < n && k < st_d.size(); k++) begin
      chk("strobe_time", st_t[k], c0 + 4 + k * d);
      chk("strobe_data", st_d[k], mem[k % l]);
      chk("strobe_cnt", st_c[k], k + 1);
    end
    chk("n_reads", rd_a.size(), n);
    for (int k = 0; k < n && k < rd_a.size(); k++) chk("rd_addr", rd_a[k], k % l);
    chk("final_cnt", rcnt, n);
    chk("done_hi", done, 1);
    chk("busy_end", busy, 0);
    chk("no_err", err_cnt, e0);
    start = 1'b0;
    step();
    chk("done_lo", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  task automatic reject(input int l, input int d, input logic w);
    int e0; logic [31:0] c0;
    clear_mon();
    len = (AW+1)'(l); div = d; cnum = 16'd1; wr_en = w;
    c0 = rcnt; e0 = err_cnt;
    step();
    start = 1'b1;
    repeat (4) step();
    chk("rej_err", err_cnt - e0, 1);
    chk("rej_busy", busy, 0);
    chk("rej_rd", rd_a.size(), 0);
    chk("rej_cnt", rcnt, c0);
    start = 1'b0; wr_en = 1'b0;
    step();
  endtask

  initial begin
    int e0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    mem[0] = 16'h0011; mem[1] = 16'h0022; mem[2] = 16'h0033; mem[3] = 16'h0044;
    repeat (3) step();
    chk("rst_data", wf_data, 0);
    chk("rst_valid", wf_valid, 0);
    chk("rst_cnt", rcnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rden", rd_en, 0);
    rst_n = 1'b1;
    step();

    run_finite(4, 3, 2);

    // Infinite single-sample loop, stopped after 10 strobes
    clear_mon();
    len = 1; div = 2; cnum = 0;
    step();
    start = 1'b1;
    for (int i = 0; i < 60 && st_d.size() < 10; i++) step();
    start = 1'b0;
    step();
    chk("inf_busy", busy, 0);
    chk("inf_cnt", rcnt, 10);
    chk("inf_n", st_d.size(), 10);
    for (int k = 0; k < st_d.size(); k++) chk("inf_data", st_d[k], 16'h0011);
    for (int k = 1; k < st_t.size(); k++) chk("inf_space", st_t[k] - st_t[k-1], 2);
    for (int k = 0; k < rd_a.size(); k++) chk("inf_addr", rd_a[k], 0);

    reject(0, 3, 1'b0);
    reject(4, 1, 1'b0);
    reject(4, 3, 1'b1);
    reject(1025, 3, 1'b0);

    run_finite(1024, 2, 1);

    // write_en abort right after the 5th strobe, then a clean restart
    clear_mon();
    len = 8; div = 3; cnum = 0;
    step();
    start = 1'b1; e0 = err_cnt;
    for (int i = 0; i < 60 && st_d.size() < 5; i++) step();
    wr_en = 1'b1;
    step();
    chk("wab_busy", busy, 0);
    chk("wab_data", wf_data, mem[4]);
    chk("wab_cnt", rcnt, 5);
    step();
    chk("wab_err", err_cnt - e0, 1);
    chk("wab_n", st_d.size(), 5);
    wr_en = 1'b0; start = 1'b0;
    step();
    run_finite(4, 3, 1);

    // start dropped in the same clock as a tick: no strobe, no count
    clear_mon();
    len = 4; div = 3; cnum = 0;
    step();
    start = 1'b1;
    for (int i = 0; i < 60 && st_d.size() < 2; i++) step();
    step(); step();
    start = 1'b0;
    step();
    chk("col_valid", wf_valid, 0);
    chk("col_n", st_d.size(), 2);
    chk("col_cnt", rcnt, 2);
    chk("col_busy", busy, 0);
    chk("col_data", wf_data, mem[1]);

    for (int r = 0; r < 4; r++)
      run_finite(int'($urandom_range(1, 20)), int'($urandom_range(2, 6)), int'($urandom_range(1, 3)));

    // Asynchronous reset between clock edges during a run
    clear_mon();
    len = 8; div = 4; cnum = 0;
    step();
    start = 1'b1;
    for (int i = 0; i < 60 && st_d.size() < 3; i++) step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_data", wf_data, 0);
    chk("arst_cnt", rcnt, 0);
    chk("arst_busy", busy, 0);
    chk("arst_valid", wf_valid, 0);
    chk("arst_rden", rd_en, 0);
    step(); step();
    clear_mon();
    rst_n = 1'b1;
    repeat (6) step();
    chk("arst_noedge_busy", busy, 0);
    chk("arst_noedge_str", st_d.size(), 0);
    chk("arst_noedge_rd", rd_a.size(), 0);
    start = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
